alu_sched: RTL and testbench

ALU_SCHED -- requirements
Module: alu_sched

---
 rtl/alu_sched.sv | 147 ++++++++++++++
 tb/tb_alu_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Two-requester ALU scheduler: arbitrates, executes one ALU op, holds the response until accepted.
// Build option ALU_SCHED_FIXED_PRI_EN: requester 0 always wins ties instead of round-robin.

module alu (
  input  logic [1:0]  op,
  input  logic [15:0] i0,
  input  logic [15:0] i1,
  output logic [15:0] o,
  output logic        cout
);
  logic [16:0] w_sum;

  // op: 00 add, 01 subtract (cout = no borrow), 10 and, 11 or
  always_comb begin
    w_sum = 17'd0;
    o     = 16'd0;
    cout  = 1'b0;
    case (op)
      2'b00: begin
        w_sum = {1'b0, i0} + {1'b0, i1};
        o     = w_sum[15:0];
        cout  = w_sum[16];
      end
      2'b01: begin
        w_sum = {1'b0, i0} + {1'b0, ~i1} + 17'd1;
        o     = w_sum[15:0];
        cout  = w_sum[16];
      end
      2'b10:   o = i0 & i1;
      default: o = i0 | i1;
    endcase
  end
endmodule

module alu_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [15:0]      a0,
  input  logic [15:0]      b0,
  input  logic [15:0]      a1,
  input  logic [15:0]      b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [15:0]      rsp_data,
  output logic             rsp_cout,
  output logic             busy,
  output logic [CNT_W-1:0] txn_cnt
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic        w_any;
  logic        w_win;
  logic [15:0] w_alu_o;
  logic        w_alu_c;
`ifdef ALU_SCHED_FIXED_PRI_EN
`else
  logic        r_last;
`endif

  assign w_any = req0 | req1;
  assign busy  = (r_state != IDLE);

`ifdef ALU_SCHED_FIXED_PRI_EN
  assign w_win = ~req0;
`else
  // on a tie the requester not served last wins
  assign w_win = (req0 & req1) ? ~r_last : req1;
`endif

  alu u_alu (
    .op   (r_op),
    .i0   (r_a),
    .i1   (r_b),
    .o    (w_alu_o),
    .cout (w_alu_c)
  );

  // operand capture: data only, loaded on acceptance
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_any) begin
      r_op <= w_win ? op1 : op0;
      r_a  <= w_win ? a1  : a0;
      r_b  <= w_win ? b1  : b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= 16'd0;
      rsp_cout  <= 1'b0;
      txn_cnt   <= '0;
`ifdef ALU_SCHED_FIXED_PRI_EN
`else
      r_last    <= 1'b1;
`endif
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            gnt0    <= ~w_win;
            gnt1    <= w_win;
            rsp_id  <= w_win;
            r_state <= EXEC;
`ifdef ALU_SCHED_FIXED_PRI_EN
`else
            r_last  <= w_win;
`endif
          end
        end
        EXEC: begin
          rsp_data  <= w_alu_o;
          rsp_cout  <= w_alu_c;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            txn_cnt   <= txn_cnt + CNT_W'(1);
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: vector table, hand-written corner sequences, random traffic
// against a behavioural model; a second instance with CNT_W=2 exercises counter wrap.

module tb_alu_sched;
  logic        clk = 1'b0;
  logic        reset, req0, req1, rsp_ready;
  logic [1:0]  op0, op1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, rsp_valid, rsp_id, rsp_cout, busy;
  logic [15:0] rsp_data;
  logic [7:0]  txn_cnt;
  logic        g0_2, g1_2, v_2, id_2, c_2, busy_2;
  logic [15:0] d_2;
  logic [1:0]  cnt_2;

  int   checks = 0;
  int   errors = 0;
  logic m_last;
  int   m_cnt;

`ifdef ALU_SCHED_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_sched #(.CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_cout(rsp_cout), .busy(busy), .txn_cnt(txn_cnt)
  );

  alu_sched #(.CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(g0_2), .gnt1(g1_2),
    .rsp_valid(v_2), .rsp_ready(rsp_ready), .rsp_id(id_2),
    .rsp_data(d_2), .rsp_cout(c_2), .busy(busy_2), .txn_cnt(cnt_2)
  );

  typedef struct {
    logic        r0, r1;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic [15:0] ed;
    logic        ec;
    logic        eid;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ALU behaviour from arithmetic rules: add carry, subtract reports a >= b
  function automatic logic [16:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned s;
    case (op)
      2'b00: begin s = a + b; return {s > 32'hffff, 16'(s)}; end
      2'b01: return {a >= b, 16'(a - b)};
      2'b10: return {1'b0, a & b};
      default: return {1'b0, a | b};
    endcase
  endfunction

  function automatic logic pick(input logic r0, input logic r1);
    if (r0 && !r1) return 1'b0;
    if (r1 && !r0) return 1'b1;
    return FIXED ? 1'b0 : ~m_last;
  endfunction

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_gnt"}, {gnt0, gnt1, g0_2, g1_2}, 4'b0);
    chk({nm, "_valid"}, {rsp_valid, v_2}, 2'b0);
    chk({nm, "_id"}, {rsp_id, id_2}, 2'b0);
    chk({nm, "_data"}, {rsp_data, d_2}, 32'h0);
    chk({nm, "_cout"}, {rsp_cout, c_2}, 2'b0);
    chk({nm, "_busy"}, {busy, busy_2}, 2'b0);
    chk({nm, "_cnt"}, {txn_cnt, cnt_2}, 10'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b0;
    tick();
    chk_reset_outs("reset");
    reset = 1'b0;
    m_last = 1'b1;
    m_cnt = 0;
  endtask

  task automatic do_txn(input logic r0, input logic r1,
                        input logic [1:0] p0, input logic [15:0] x0, input logic [15:0] y0,
                        input logic [1:0] p1, input logic [15:0] x1, input logic [15:0] y1,
                        input int hold, input logic raise1,
                        input logic [15:0] ed, input logic ec, input logic eid, input string nm);
    req0 = r0; req1 = r1; op0 = p0; a0 = x0; b0 = y0; op1 = p1; a1 = x1; b1 = y1;
    rsp_ready = 1'b0;
    tick();
    chk({nm, "_gnt"}, {gnt0, gnt1, g0_2, g1_2}, {~eid, eid, ~eid, eid});
    chk({nm, "_busy_acc"}, {busy, busy_2, rsp_valid}, 3'b110);
    tick();
    chk({nm, "_gnt_exec"}, {gnt0, gnt1, g0_2, g1_2}, 4'b0);
    chk({nm, "_valid"}, {rsp_valid, v_2}, 2'b11);
    chk({nm, "_rsp"}, {rsp_id, rsp_cout, rsp_data}, {eid, ec, ed});
    chk({nm, "_rsp2"}, {id_2, c_2, d_2}, {eid, ec, ed});
    for (int h = 0; h < hold; h++) begin
      if (raise1) req1 = 1'b1;
      tick();
      chk({nm, "_hold"}, {rsp_valid, gnt0, gnt1, rsp_id, rsp_cout, rsp_data},
          {3'b100, eid, ec, ed});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    m_last = eid;
    m_cnt++;
    chk({nm, "_done"}, {rsp_valid, busy, gnt0, gnt1}, 4'b0);
    chk({nm, "_cnt"}, txn_cnt, m_cnt & 8'hff);
    chk({nm, "_cnt2"}, cnt_2, m_cnt & 3);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] e;
    logic        w;
    logic        r0, r1;
    logic [1:0]  p0, p1;
    logic [15:0] x0, y0, x1, y1;

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b0;
    op0 = 2'b0; op1 = 2'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick();
    do_reset();

    vecs[0] = '{1'b1, 1'b0, 2'b00, 16'hffff, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 2'b00, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 2'b01, 16'h0005, 16'h0003, 16'h0002, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 2'b01, 16'h0003, 16'h0005, 16'hfffe, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 2'b10, 16'hf0f0, 16'hff00, 16'hf000, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 2'b11, 16'h0f0f, 16'h00f0, 16'h0fff, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 2'b01, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b1};

    // losing side carries unrelated operands so a wrong mux select shows up
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].r0)
        do_txn(1'b1, 1'b0, vecs[i].op, vecs[i].a, vecs[i].b, ~vecs[i].op, 16'hdead, 16'hbeef,
               i % 3, 1'b0, vecs[i].ed, vecs[i].ec, vecs[i].eid, $sformatf("vec%0d", i));
      else
        do_txn(1'b0, 1'b1, ~vecs[i].op, 16'hdead, 16'hbeef, vecs[i].op, vecs[i].a, vecs[i].b,
               i % 3, 1'b0, vecs[i].ed, vecs[i].ec, vecs[i].eid, $sformatf("vec%0d", i));
    end

    // rsp_ready while idle must not count anything
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ready", {rsp_valid, busy, gnt0, gnt1, txn_cnt}, {4'b0, 8'(m_cnt)});
    end
    rsp_ready = 1'b0;

    // both requesters held: round-robin 0,1,0,1 or fixed 0,0,0,0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      w = FIXED ? 1'b0 : 1'(k % 2);
      do_txn(1'b1, 1'b1, 2'b00, 16'h0001, 16'h7fff, 2'b00, 16'haa55, 16'h55aa, 0, 1'b0,
             w ? 16'hffff : 16'h8000, 1'b0, w, $sformatf("tie%0d", k));
    end

    // long stall with req1 raised during RESP, then req1 served
    do_txn(1'b1, 1'b0, 2'b10, 16'h3c3c, 16'h0ff0, 2'b00, 16'h0, 16'h0, 5, 1'b1,
           16'h0c30, 1'b0, 1'b0, "stall");
    do_txn(1'b0, 1'b1, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0102, 16'h0304, 0, 1'b0,
           16'h0406, 1'b0, 1'b1, "after_stall");

    // reset during EXEC abandons the transaction
    req1 = 1'b1; op1 = 2'b00; a1 = 16'h1111; b1 = 16'h2222;
    tick();
    chk("rst_exec_pre", {busy, gnt1}, 2'b11);
    reset = 1'b1; req1 = 1'b0;
    tick();
    chk_reset_outs("rst_exec");
    reset = 1'b0;
    m_last = 1'b1;
    m_cnt = 0;
    tick();
    tick();
    chk("rst_exec_after", {rsp_valid, busy, txn_cnt}, 10'h0);

    // random traffic; counter wrap on the CNT_W=2 instance gives 1,2,3,0,1,...
    for (int t = 0; t < 60; t++) begin
      r0 = 1'($urandom); r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      p0 = 2'($urandom); p1 = 2'($urandom);
      x0 = 16'($urandom); y0 = 16'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
      w = pick(r0, r1);
      e = w ? ref_alu(p1, x1, y1) : ref_alu(p0, x0, y0);
      do_txn(r0, r1, p0, x0, y0, p1, x1, y1, $urandom_range(0, 2), 1'($urandom),
             e[15:0], e[16], w, $sformatf("rnd%0d", t));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        chk("rnd_gap", {busy, gnt0, gnt1, rsp_valid}, 4'b0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
